// File: rtl/runtime_cfg_if.sv
// Shadow-write and commit request bundle for runtime_cfg_ctrl.
// master drives requests, slave returns the ready signals.
interface runtime_cfg_if #(
  parameter int NrHarts  = 1,
  parameter int CfgWidth = 32
);
  localparam int HartW = (NrHarts > 1) ? $clog2(NrHarts) : 1;

  logic                wr_valid_i;
  logic                wr_ready_o;
  logic [HartW-1:0]    wr_hart_i;
  logic [CfgWidth-1:0] wr_data_i;
  logic                commit_valid_i;
  logic                commit_ready_o;
  logic [HartW-1:0]    commit_hart_i;

  modport master (
    output wr_valid_i, wr_hart_i, wr_data_i,
    output commit_valid_i, commit_hart_i,
    input  wr_ready_o, commit_ready_o
  );

  modport slave (
    input  wr_valid_i, wr_hart_i, wr_data_i,
    input  commit_valid_i, commit_hart_i,
    output wr_ready_o, commit_ready_o
  );
endinterface

// File: rtl/runtime_cfg_ctrl.sv
// Per-hart shadow/active feature vectors with drain-then-apply commit.
// Optional active-register parity: define RUNTIME_CFG_PARITY_EN.
module runtime_cfg_ctrl #(
  parameter int                 NrHarts      = 1,
  parameter int                 CfgWidth     = 32,
  parameter logic [CfgWidth-1:0] BuildMask   = '1,
  parameter logic [CfgWidth-1:0] ResetCfg    = '0,
  parameter int                 FBit         = 5,
  parameter int                 DBit         = 3,
  parameter int                 DrainTimeout = 255
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  runtime_cfg_if.slave                 cfg_bus,
  output logic [NrHarts-1:0]           drain_req_o,
  input  logic [NrHarts-1:0]           drain_ack_i,
  output logic [NrHarts*CfgWidth-1:0]  shadow_cfg_o,
  output logic [NrHarts*CfgWidth-1:0]  active_cfg_o,
  output logic                         commit_done_o,
  output logic                         commit_err_o,
  output logic [NrHarts-1:0]           parity_err_o
);
  localparam int HartW = (NrHarts > 1) ? $clog2(NrHarts) : 1;
  localparam int CntW  = (DrainTimeout > 1) ? $clog2(DrainTimeout + 1) : 1;
  localparam logic [31:0] NrHartsU = NrHarts;

  typedef logic [CfgWidth-1:0] cfg_t;
  typedef enum logic [1:0] {IDLE, DRAIN, APPLY} state_e;

  // D implies F: promote F when built, otherwise drop D.
  function automatic cfg_t legalize(input cfg_t x);
    cfg_t y;
    y = x & BuildMask;
    if (y[DBit]) begin
      if (BuildMask[FBit]) y[FBit] = 1'b1;
      else                 y[DBit] = 1'b0;
    end
    return y;
  endfunction

  state_e                    state_q, state_d;
  logic [HartW-1:0]          tgt_q, tgt_d;
  logic [CntW-1:0]           cnt_q, cnt_d;
  cfg_t [NrHarts-1:0]        shadow_q, shadow_d;
  cfg_t [NrHarts-1:0]        active_q, active_d;
  logic [NrHarts-1:0]        drain_q, drain_d;
  logic                      done_q, done_d;
  logic                      err_q, err_d;

  logic [NrHarts-1:0]        tgt_oh, cmt_oh;
  logic                      wr_fire, cmt_fire;
  logic                      cmt_in_range, ack_tgt;
  logic [CntW-1:0]           cnt_inc;

  always_comb begin
    tgt_oh = '0;
    cmt_oh = '0;
    for (int h = 0; h < NrHarts; h++) begin
      tgt_oh[h] = (tgt_q == HartW'(h));
      cmt_oh[h] = (cfg_bus.commit_hart_i == HartW'(h));
    end
  end

  assign cfg_bus.wr_ready_o =
    !((state_q != IDLE) && (cfg_bus.wr_hart_i == tgt_q));
  assign cfg_bus.commit_ready_o = (state_q == IDLE);

  assign wr_fire  = cfg_bus.wr_valid_i & cfg_bus.wr_ready_o;
  assign cmt_fire = cfg_bus.commit_valid_i & cfg_bus.commit_ready_o;
  assign cmt_in_range = 32'(cfg_bus.commit_hart_i) < NrHartsU;
  assign ack_tgt = |(drain_ack_i & tgt_oh);
  assign cnt_inc = cnt_q + CntW'(1);

  always_comb begin
    state_d  = state_q;
    tgt_d    = tgt_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    active_d = active_q;
    drain_d  = '0;
    done_d   = 1'b0;
    err_d    = 1'b0;

    for (int h = 0; h < NrHarts; h++) begin
      if (wr_fire && cfg_bus.wr_hart_i == HartW'(h))
        shadow_d[h] = legalize(cfg_bus.wr_data_i);
    end

    unique case (state_q)
      IDLE: begin
        if (cmt_fire) begin
          tgt_d = cfg_bus.commit_hart_i;
          cnt_d = '0;
          if (cmt_in_range) begin
            state_d = DRAIN;
            drain_d = cmt_oh;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      DRAIN: begin
        cnt_d = cnt_inc;
        if (ack_tgt) begin
          state_d = APPLY;
        end else if (cnt_inc == CntW'(DrainTimeout)) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          drain_d = tgt_oh;
        end
      end
      APPLY: begin
        for (int h = 0; h < NrHarts; h++) begin
          if (tgt_oh[h]) active_d[h] = shadow_q[h];
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      tgt_q    <= '0;
      cnt_q    <= '0;
      shadow_q <= {NrHarts{legalize(ResetCfg)}};
      active_q <= {NrHarts{legalize(ResetCfg)}};
      drain_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tgt_q    <= tgt_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      drain_q  <= drain_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign drain_req_o   = drain_q;
  assign shadow_cfg_o  = shadow_q;
  assign active_cfg_o  = active_q;
  assign commit_done_o = done_q;
  assign commit_err_o  = err_q;

`ifdef RUNTIME_CFG_PARITY_EN
  logic [NrHarts-1:0] par_q, par_d;
  logic [NrHarts-1:0] perr_q, perr_d;

  // Sticky mismatch; a successful apply rewrites parity and clears it.
  always_comb begin
    par_d  = par_q;
    perr_d = perr_q;
    for (int h = 0; h < NrHarts; h++) begin
      if (par_q[h] != ^active_q[h]) perr_d[h] = 1'b1;
      if (state_q == APPLY && tgt_oh[h]) begin
        par_d[h]  = ^shadow_q[h];
        perr_d[h] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      par_q  <= {NrHarts{^legalize(ResetCfg)}};
      perr_q <= '0;
    end else begin
      par_q  <= par_d;
      perr_q <= perr_d;
    end
  end

  assign parity_err_o = perr_q;
`else
  assign parity_err_o = '0;
`endif
endmodule
